// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the FP32 multiplier arbiter.
package fp_mult_pkg;

  localparam int FP32_W   = 32;
  localparam int EXP_BIAS = 127;

  // IDLE: arbitrate; WAIT: multiplier busy; RESP: product held for the requester.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fp_mult_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Walk the requesters starting at ptr; the first one found wins.
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    int            pos;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = IW'(pos);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one FP32 multiplier between NREQ requesters, one op in flight.
//
// Handshakes:
//  - Request: requester i holds req_valid[i] with operands on its slice.
//    The arbiter samples req_valid only in IDLE and pulses req_ready[g] for
//    exactly one cycle; the op is accepted on the clock edge ending that cycle.
//  - Response: rsp_valid[gid] rises with rsp_data and both stay stable until
//    rsp_ready[gid] is seen high on a clock edge; other rsp_ready bits are ignored.
module fp_mult_arbiter
  import fp_mult_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [FP32_W*NREQ-1:0] req_a,
  input  logic [FP32_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [FP32_W-1:0]      rsp_data,
  output logic [FP32_W-1:0]      mul_a,
  output logic [FP32_W-1:0]      mul_b,
  input  logic [FP32_W-1:0]      mul_res,
  output logic                   busy,
  output state_t                 state
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     gid;
  logic [CW-1:0]     cnt;
  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;
  logic              any;
  logic [FP32_W-1:0] sel_a;
  logic [FP32_W-1:0] sel_b;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Operand slice of the currently winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IW'(k)) begin
        sel_a = req_a[FP32_W*k +: FP32_W];
        sel_b = req_b[FP32_W*k +: FP32_W];
      end
    end
  end

  // Accept pulse exists only while arbitrating; suppressed while reset is held.
  assign req_ready = (state == IDLE && !reset) ? gnt : '0;
  assign busy      = (state != IDLE);

  // Control FSM: accept, wait MUL_LAT cycles for the product, hand it back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gid       <= '0;
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
            gid   <= gnt_idx;
            cnt   <= CW'(MUL_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            rsp_data  <= mul_res;
            rsp_valid <= ONE << gid;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[gid]) begin
            rsp_valid <= '0;
            rr_ptr    <= (gid == IW'(NREQ - 1)) ? '0 : gid + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter: per-requester operand queues feed a
// driver, expected grants/responses are queued by the stimulus and popped by
// an independent monitor.
module tb_fp_mult_arbiter;
  import fp_mult_pkg::*;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 3;
  localparam int W       = 36;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a = '0;
  logic [32*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready = '1;
  logic [31:0]        rsp_data;
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic [31:0]        mul_res;
  logic               busy;
  state_t             state;

  fp_mult_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_res   (mul_res),
    .busy      (busy),
    .state     (state)
  );

  // ---------------- behavioural multiplier ----------------
  // Normal operands only, truncating; vectors below are exact products.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      return {s, e[7:0], p[46:24]};
    end
    return {s, e[7:0], p[45:23]};
  endfunction

  // Product valid MUL_LAT cycles after the operands settle.
  logic [31:0] mul_pipe [MUL_LAT-1];
  always @(posedge clk) begin
    mul_pipe[0] <= fp_mul(mul_a, mul_b);
    for (int k = 1; k < MUL_LAT - 1; k++) mul_pipe[k] <= mul_pipe[k-1];
  end
  assign mul_res = mul_pipe[MUL_LAT-2];

  // ---------------- scoreboard state ----------------
  logic [63:0]    op_q [NREQ][$];
  logic [3:0]     gnt_q[$];
  logic [W-1:0]   exp_q[$];
  int             n_cmp = 0;
  int             n_err = 0;
  int             acc_cyc = 0;
  logic [NREQ-1:0] prev_rsp = '0;
  logic           saw_rdy3 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b);
    op_q[i].push_back({a, b});
  endtask

  task automatic expect_op(input int i, input logic [31:0] d);
    gnt_q.push_back(4'(i));
    exp_q.push_back({4'(i), d});
  endtask

  // Requester model: present the head op, retire it once accepted.
  always begin
    logic [NREQ-1:0] seen;
    @(negedge clk);
    seen = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (seen[i] && op_q[i].size() > 0) void'(op_q[i].pop_front());
      if (op_q[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_a[32*i +: 32]   = op_q[i][0][63:32];
        req_b[32*i +: 32]   = op_q[i][0][31:0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [3:0]      gi;
    logic [W-1:0]    e;
    logic [NREQ-1:0] oh;
    if (reset) begin
      prev_rsp = '0;
    end else begin
      if (req_ready[3]) saw_rdy3 = 1'b1;
      if (req_ready != '0) begin
        if (gnt_q.size() == 0) flag("grant_unexpected");
        else begin
          gi = gnt_q.pop_front();
          oh = NREQ'(1) << gi;
          check("grant", 64'(req_ready), 64'(oh));
        end
        acc_cyc = cyc;
      end
      if (rsp_valid != '0 && prev_rsp == '0)
        check("latency", 64'(cyc - acc_cyc - 1), 64'(MUL_LAT));
      if ((rsp_valid & rsp_ready) != '0) begin
        if (exp_q.size() == 0) flag("response_unexpected");
        else begin
          e  = exp_q.pop_front();
          oh = NREQ'(1) << e[35:32];
          check("response", {28'd0, rsp_valid, rsp_data}, {28'd0, oh, e[31:0]});
        end
      end
      prev_rsp = rsp_valid;
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && gnt_q.size() == 0 && !busy &&
          op_q[0].size() == 0 && op_q[1].size() == 0 &&
          op_q[2].size() == 0 && op_q[3].size() == 0) return;
    end
    flag("timeout_wait_done");
    exp_q.delete();
    gnt_q.delete();
    for (int i = 0; i < NREQ; i++) op_q[i].delete();
  endtask

  task automatic wait_rsp(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) return;
    end
    flag("timeout_wait_rsp");
  endtask

  task automatic wait_grant(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (req_ready != '0) return;
    end
    flag("timeout_wait_grant");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state, with a request already waiting.
    reset     = 1'b1;
    rsp_ready = '1;
    push_op(0, 32'h4000_0000, 32'h4040_0000);  // 2.0 * 3.0
    expect_op(0, 32'h40C0_0000);
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data",  64'(rsp_data),  64'd0);
    check("reset_mul_a",     64'(mul_a),     64'd0);
    check("reset_mul_b",     64'(mul_b),     64'd0);
    check("reset_busy",      64'(busy),      64'd0);
    check("reset_state",     64'(state),     64'(IDLE));
    @(posedge clk); #2 reset = 1'b0;
    wait_done(50);

    // All four requesters, req0 twice: order 0,1,2,3,0 from a fresh pointer.
    pulse_reset();
    @(negedge clk);
    push_op(0, 32'h4000_0000, 32'h4040_0000);  // 2 * 3
    push_op(1, 32'h3F80_0000, 32'hC000_0000);  // 1 * -2
    push_op(2, 32'h4080_0000, 32'h3F00_0000);  // 4 * 0.5
    push_op(3, 32'hC040_0000, 32'hC0A0_0000);  // -3 * -5
    push_op(0, 32'h3FC0_0000, 32'h3FC0_0000);  // 1.5 * 1.5
    expect_op(0, 32'h40C0_0000);
    expect_op(1, 32'hC000_0000);
    expect_op(2, 32'h4000_0000);
    expect_op(3, 32'h4170_0000);
    expect_op(0, 32'h4010_0000);
    wait_done(200);

    // Stall on requester 1 (pointer now 1) while 3 waits; other ready bits high.
    rsp_ready = 4'b1101;
    push_op(1, 32'h40A0_0000, 32'h4000_0000);  // 5 * 2
    push_op(3, 32'h3F80_0000, 32'h3F80_0000);  // 1 * 1
    expect_op(1, 32'h4120_0000);
    expect_op(3, 32'h3F80_0000);
    wait_rsp(30);
    for (int c = 0; c < 5; c++) begin
      check("stall_rsp_valid", 64'(rsp_valid), 64'h2);
      check("stall_rsp_data",  64'(rsp_data),  64'h4120_0000);
      check("stall_busy",      64'(busy),      64'd1);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = '1;
    wait_done(100);

    // Reset during WAIT drops the op; pointer returns to 0.
    push_op(0, 32'h4040_0000, 32'h4040_0000);
    gnt_q.push_back(4'd0);
    wait_grant(20);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("abort_req_ready", 64'(req_ready), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_rsp_data",  64'(rsp_data),  64'd0);
    check("abort_mul_a",     64'(mul_a),     64'd0);
    check("abort_mul_b",     64'(mul_b),     64'd0);
    check("abort_busy",      64'(busy),      64'd0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_rsp",  64'(rsp_valid), 64'd0);
    check("abort_idle",    64'(busy),      64'd0);
    check("abort_gnt_q",   64'(gnt_q.size()), 64'd0);
    push_op(0, 32'hBF80_0000, 32'h40E0_0000);  // -1 * 7
    push_op(2, 32'h4080_0000, 32'h3F00_0000);  // 4 * 0.5
    expect_op(0, 32'hC0E0_0000);
    expect_op(2, 32'h4000_0000);
    wait_done(100);

    // Pointer 3: req2 alone, then req2 again with req1 pending -> req1 first.
    push_op(2, 32'h4100_0000, 32'h3F40_0000);  // 8 * 0.75
    expect_op(2, 32'h40C0_0000);
    wait_done(50);
    push_op(2, 32'h3F00_0000, 32'h3F00_0000);  // 0.5 * 0.5
    push_op(1, 32'h4040_0000, 32'h4040_0000);  // 3 * 3
    expect_op(1, 32'h4110_0000);
    expect_op(2, 32'h3E80_0000);
    wait_done(100);

    // req_valid[3] pulsed while busy, withdrawn before arbitration.
    saw_rdy3 = 1'b0;
    push_op(0, 32'h4040_0000, 32'hBF00_0000);  // 3 * -0.5
    expect_op(0, 32'hBFC0_0000);
    wait_grant(20);
    @(negedge clk);
    push_op(3, 32'h4000_0000, 32'h4000_0000);
    @(negedge clk);
    op_q[3].delete();
    wait_done(50);
    repeat (4) @(negedge clk);
    check("pulse_no_ready3", 64'(saw_rdy3),  64'd0);
    check("pulse_idle",      64'(busy),      64'd0);
    check("pulse_req_ready", 64'(req_ready), 64'd0);
    check("final_exp_q",     64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
